// File: rtl/mult_div.sv
// -----------------------------------------------------------------------------
// mult_div -- iterative multiply/divide unit holding the MIPS HI/LO registers.
//
// Executes MULT, MULTU, DIV and DIVU one radix-2 step per clock, and services
// MTHI/MTLO writes. MFHI/MFLO are served straight from the HI/LO outputs.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset (aborts any operation)
//   start  in   launch operation 'op' on A, B (only looked at while idle)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A      in   rs operand, also MTHI/MTLO data
//   B      in   rt operand
//   mthi   in   write A into HI (idle only, dropped if start is also high)
//   mtlo   in   write A into LO (idle only, dropped if start is also high)
//   busy   out  operation in progress
//   done   out  one-cycle pulse the cycle after HI/LO take a result
//   HI     out  product high word / remainder
//   LO     out  product low word / quotient
// -----------------------------------------------------------------------------
module mult_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            mthi,
    input  logic            mtlo,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]   ONE_X  = 1;
    localparam logic [2*XLEN-1:0] ONE_2X = 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Multiply: {acc, multiplier}.  Divide: {rem, quot}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand magnitude or divisor magnitude.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;   // negate product / quotient
    logic              neg_rem_q, neg_rem_d;   // remainder takes dividend sign
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d;

    // Operand decode for a launch in IDLE.
    logic            op_signed, op_div, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign a_neg     = op_signed & A[XLEN-1];
    assign b_neg     = op_signed & B[XLEN-1];
    // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
    assign a_mag     = a_neg ? (~A + ONE_X) : A;
    assign b_mag     = b_neg ? (~B + ONE_X) : B;

    // One shift-add multiply step.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring divide step: shift, trial-subtract, keep if no borrow.
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   rem_diff;
    logic [2*XLEN-1:0] div_next;
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    assign div_next = rem_diff[XLEN+1]
                    ? {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                    : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // Sign-corrected results.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    assign prod_fix = neg_res_q ? (~acc_q + ONE_2X) : acc_q;
    assign quot_fix = neg_res_q ? (~acc_q[XLEN-1:0] + ONE_X) : acc_q[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_X) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_rem_d = a_neg;
                    if (op_div) begin
                        opnd_d = b_mag;
                        if (B == '0) begin
                            // Divide by zero: preload rem=|A|, quot=all ones and
                            // skip the iterations; the FIX sign logic rebuilds A.
                            acc_d     = {a_mag, {XLEN{1'b1}}};
                            neg_res_d = 1'b0;
                            state_d   = S_FIX;
                        end else begin
                            acc_d     = {{XLEN{1'b0}}, a_mag};
                            neg_res_d = a_neg ^ b_neg;
                            state_d   = S_CALC;
                        end
                    end else begin
                        opnd_d    = a_mag;
                        acc_d     = {{XLEN{1'b0}}, b_mag};
                        neg_res_d = a_neg ^ b_neg;
                        state_d   = S_CALC;
                    end
                end else begin
                    if (mthi) hi_d = A;
                    if (mtlo) lo_d = A;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// -----------------------------------------------------------------------------
// tb_mult_div -- self-checking bench for mult_div.
// An arithmetic reference model predicts busy/done/HI/LO every cycle; directed
// vectors add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mult_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: what HI/LO must become, and how many cycles busy lasts.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        lat = 33;
        hi  = '0;
        lo  = '0;
        case (o)
            2'b00: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi  = a;
                    lo  = 32'hFFFF_FFFF;
                    lat = 1;
                end else if (o == 2'b10) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Cycle-level expectation, updated on the same edges the DUT uses.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (start) begin
                model_op(op, A, B, p_hi, p_lo, m_left);
                m_busy = 1'b1;
            end else begin
                if (mthi) m_hi = A;
                if (mtlo) m_lo = A;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_hi", HI, m_hi);
            check("cyc_lo", LO, m_lo);
        end
    end

    // Launch at a negedge, wait for busy to fall, check literal results.
    // Returns at the negedge where done is high, so a following call starts
    // in the done cycle.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
        int cyc;
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
        check({nm, "_done"}, {31'b0, done}, 32'd1);
        check({nm, "_hi"}, HI, exp_hi);
        check({nm, "_lo"}, LO, exp_lo);
        $display("op %s A=0x%08h B=0x%08h -> HI=0x%08h LO=0x%08h busy=%0d", nm, a, b, HI, LO, cyc);
    endtask

    initial begin
        int cyc, dcount;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        @(negedge clk);
        check("multu_done_width", {31'b0, done}, 32'd0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        run_op("div_neg",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu",     2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("div_zero", 2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1);
        run_op("divu_zero", 2'b11, 32'h8765_4321, 32'h0, 32'h8765_4321, 32'hFFFF_FFFF, 1);

        // Start + mthi during busy are ignored.
        op = 2'b00; A = 32'd7; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 10) begin
                start = 1'b1; op = 2'b11; A = 32'hDEAD_BEEF; B = 32'd3; mthi = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
        check("ign_busy_cycles", 32'(cyc), 32'd33);
        check("ign_hi", HI, 32'h0);
        check("ign_lo", LO, 32'd42);
        $display("op mult_ignore A=0x00000007 B=0x00000006 -> HI=0x%08h LO=0x%08h busy=%0d", HI, LO, cyc);

        // Reset part-way through a DIVU: no result, no done.
        @(negedge clk);
        op = 2'b11; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        $display("op divu_abort -> HI=0x%08h LO=0x%08h done_pulses=%0d", HI, LO, dcount);

        // MTHI and MTLO together.
        A = 32'hCAFE_BABE; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", HI, 32'hCAFE_BABE);
        check("mthilo_lo", LO, 32'hCAFE_BABE);
        $display("op mthi_mtlo A=0xcafebabe -> HI=0x%08h LO=0x%08h", HI, LO);

        // start wins over mtlo; LO holds old value while busy.
        op = 2'b01; A = 32'd3; B = 32'd4; start = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        check("hold_lo_busy", LO, 32'hCAFE_BABE);
        cyc = 1;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        cyc--;
        check("startwin_busy_cycles", 32'(cyc), 32'd33);
        check("startwin_hi", HI, 32'h0);
        check("startwin_lo", LO, 32'd12);
        $display("op multu_mtlo A=0x00000003 B=0x00000004 -> HI=0x%08h LO=0x%08h busy=%0d", HI, LO, cyc);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not implement.
- Also services MTHI/MTLO writes; MFHI/MFLO read the HI/LO outputs directly.
- Sits beside the ALU in the execute stage. Control stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation op on A, B; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  32  rs operand; also the MTHI/MTLO data.
- B  input  32  rt operand.
- mthi  input  1  write A into HI; honoured only in IDLE.
- mtlo  input  1  write A into LO; honoured only in IDLE.
- busy  output  1  operation in progress; high from the start edge until the result edge.
- done  output  1  one-cycle pulse, high the cycle after HI/LO take a result.
- HI  output  32  HI register (product high word / remainder).
- LO  output  32  LO register (product low word / quotient).

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - state=IDLE, HI=LO=0, busy=0, done=0, counter=0, internal accumulators=0.
  - A reset mid-operation aborts it; no partial result reaches HI/LO.
- States are IDLE, CALC and FIX.
- IDLE:
  - If start=1 at edge E0: latch operand magnitudes and result-sign flags, then go to CALC with count=0 and busy=1.
  - For signed ops, magnitude = two's-complement absolute value; 0x80000000 maps to unsigned 2^31.
  - Unsigned ops take operands as-is.
  - If start=0: mthi/mtlo write A into HI/LO at that edge; both may assert together.
  - start=1 in the same cycle as mthi/mtlo: start wins and the writes are dropped.
- DIV/DIVU with B=0 at E0: go straight to FIX and skip CALC.
- CALC: one radix-2 step per edge, E1..E32; count increments each step and leaves CALC when count reaches XLEN-1.
  - Multiply: shift-add on a 64-bit {acc, multiplier} register; if LSB=1, add the multiplicand to the upper 33 bits, then shift right 1.
  - Divide: restoring on {rem, quot}; shift left 1 and trial-subtract the divisor from the 33-bit remainder; if non-negative, keep it and set the quotient LSB to 1.
- FIX at E33 writes HI/LO, sets busy=0, pulses done=1, and returns to IDLE.
  - Multiply: {HI,LO} = 64-bit product, negated when exactly one signed operand was negative.
  - Divide: LO = quotient, negated if the operand signs differ; HI = remainder, carrying the sign of the dividend (truncation toward zero).
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no exception).
  - Divide by zero (signed or unsigned): HI = A, LO = 0xFFFFFFFF. Written at E1; busy is high for one cycle only.
- done is high for exactly the one cycle after the write edge (cleared at E34, or at E2 for divide by zero).
- Latency:
  - Normal operation: 33 edges; busy is high for 33 cycles.
  - A new start is accepted in the same cycle that done is high.
- start, mthi and mtlo are ignored while busy=1; operands may change after E0 without effect.
- HI/LO hold their value between operations. Reads during busy return the previous values.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles busy falls, HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly 1 cycle.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=7 -> LO=14, HI=2. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV A=0x12345678, B=0 -> busy high 1 cycle, HI=0x12345678, LO=0xFFFFFFFF.
- Start a MULT, then at cycle 10 pulse start with different operands plus mthi -> both ignored; the original result appears at cycle 33.
- Then pulse reset at cycle 15 of a DIVU -> HI=LO=0, busy=0, no done pulse.
- IDLE: mthi=1 and mtlo=1 with A=0xCAFEBABE -> HI=LO=0xCAFEBABE next edge.
- Then start=1 with mtlo=1 -> mtlo dropped and the operation result is written.
